tt_proj_mux_ctrl: RTL and testbench
===================================

Name: tt_proj_mux_ctrl

Overview:
- Chip-side controller and mux that drives the 18-bit project input word and collects the 24-bit project output word for every tile wrapper.
- Selects one of N_PROJ projects through a pulse-counted address and sequences that project's enable and reset.
- Routes pad inputs to the selected project only, and muxes the selected project's outputs back to the pads.

Parameters:
N_PROJ, 32, number of attached project wrappers
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= N_PROJ
RST_CYC, 4, clk cycles the project reset is held after enable

Ports:
clk  input  1  controller clock
rst_n  input  1  asynchronous active-low reset
sel_rst_n  input  1  pad, async; low clears the address (honoured only in IDLE)
sel_inc  input  1  pad, async; each rising edge increments the address
sel_ena  input  1  pad, async; high requests the selected project to run
pad_clk  input  1  project clock from pad
pad_rst_n  input  1  project reset from pad, active-low
pad_ui_in  input  8  project dedicated inputs
pad_uio_in  input  8  project bidir inputs
proj_ow  input  N_PROJ*24  concatenated project output words; project k occupies bits [24k+23:24k]; word layout {uio_oe, uio_out, uo_out}
proj_iw  output  N_PROJ*18  concatenated project input words; word layout {uio_in, ui_in, rst_n, clk}
proj_ena  output  N_PROJ  one-hot project enable
pad_uo_out  output  8  selected uo_out
pad_uio_out  output  8  selected uio_out
pad_uio_oe  output  8  selected uio_oe
cur_addr  output  ADDR_W  current address
running  output  1  high in RUN

Behaviour:
- Input synchronisation:
  - sel_rst_n, sel_inc and sel_ena each pass through a 2-flop synchroniser.
  - Flop reset values: sel_rst_n 1, sel_inc 0, sel_ena 0.
  - A third flop on sel_inc supplies rising-edge detection.
  - Input-to-effect latency is 3 clk cycles.
- Address:
  - Register addr resets to 0.
  - In IDLE, a synchronised sel_inc rise sets addr to addr+1; addr N_PROJ-1 wraps to 0.
  - In IDLE, synchronised sel_rst_n=0 sets addr to 0 and takes priority over an increment in the same cycle.
  - Outside IDLE, addr is frozen; increments and clears are dropped, not queued.
- FSM states: IDLE, ARM, RUN, DRAIN. Reset state is IDLE.
  - IDLE -> ARM when synchronised sel_ena=1; load rst counter with RST_CYC-1.
  - ARM: counter decrements each cycle. -> RUN when counter=0. -> DRAIN if sel_ena drops first.
  - RUN -> DRAIN when sel_ena=0; load counter with 1.
  - DRAIN: counter decrements. -> IDLE when counter=0, giving 2 cycles in DRAIN.
- proj_ena:
  - proj_ena[addr]=1 in ARM, RUN and DRAIN; all other bits 0.
  - All bits 0 in IDLE and during reset.
- proj_iw:
  - The selected word is {pad_uio_in, pad_ui_in, prst_n, pclk}.
  - pclk = pad_clk in ARM, RUN and DRAIN, else 0.
  - prst_n is registered: 0 in IDLE, ARM and DRAIN; pad_rst_n sampled each clk in RUN.
  - Every non-selected project word is all-zero.
- Outputs:
  - pad_uo_out, pad_uio_out and pad_uio_oe are a combinational mux of proj_ow[addr] in RUN only; otherwise all 0.
  - All are 0 during reset, so uio pads are never driven outside RUN.
- running = (state==RUN). cur_addr = addr.
- Asynchronous reset mid-RUN immediately gives:
  - state IDLE, addr 0, proj_ena 0, all iw words 0, pad outputs 0.
  - Reset does not pass through a drain.
- Simultaneous sel_inc rise and sel_ena rise in one synchronised cycle: the increment applies first, then ARM starts on the new addr.

Test Plan:
- Reset, then sel_inc 3 pulses (each ≥4 clk), sel_ena=1 -> cur_addr=3; proj_ena=32'h8; ARM lasts 4 cycles; then running=1 and project 3 iw rst_n follows pad_rst_n.
- In RUN, drive proj_ow[3] to 24'hA5_5A_3C and every other project word to 24'hFFFFFF -> pad_uio_oe=8'hA5, pad_uio_out=8'h5A, pad_uo_out=8'h3C; all non-selected proj_iw words remain 0.
- In RUN, pulse sel_inc and sel_rst_n -> cur_addr stays 3. Drop sel_ena -> DRAIN holds project rst_n=0 for 2 cycles; then IDLE with proj_ena=0 and pads 0.
- From addr 31, one sel_inc -> cur_addr=0 (wrap). Then sel_rst_n low and sel_inc rise in the same cycle -> cur_addr=0.
- Drop sel_ena 2 cycles into ARM -> DRAIN then IDLE; running never asserted.
- Assert rst_n low mid-RUN at addr 7 -> outputs zero immediately without waiting for clk; after release state IDLE, addr 0.

Source files
------------

// File: rtl/tt_proj_mux_ctrl.sv
// Chip-side project selector: pulse-counted address, enable/reset sequencing,
// input routing to the selected project and output mux back to the pads.
module tt_proj_mux_ctrl #(
  parameter int N_PROJ  = 32,
  parameter int ADDR_W  = 5,
  parameter int RST_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel_rst_n,
  input  logic                 sel_inc,
  input  logic                 sel_ena,
  input  logic                 pad_clk,
  input  logic                 pad_rst_n,
  input  logic [7:0]           pad_ui_in,
  input  logic [7:0]           pad_uio_in,
  input  logic [N_PROJ*24-1:0] proj_ow,
  output logic [N_PROJ*18-1:0] proj_iw,
  output logic [N_PROJ-1:0]    proj_ena,
  output logic [7:0]           pad_uo_out,
  output logic [7:0]           pad_uio_out,
  output logic [7:0]           pad_uio_oe,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 running
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  localparam int CNT_W = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PROJ - 1);

  logic [1:0]        rsel_q, rsel_d;
  logic [2:0]        inc_q, inc_d;
  logic [1:0]        ena_q, ena_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              prst_q, prst_d;

  logic              clr_s, inc_rise, ena_s;
  logic [23:0]       sel_ow;

  // Bit [1] of each chain is the synchronised level; inc_q[2] is the previous level.
  always_comb begin
    rsel_d = {rsel_q[0], sel_rst_n};
    inc_d  = {inc_q[1:0], sel_inc};
    ena_d  = {ena_q[0], sel_ena};
  end

  assign clr_s    = ~rsel_q[1];
  assign inc_rise = inc_q[1] & ~inc_q[2];
  assign ena_s    = ena_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (clr_s) begin
          addr_d = '0;
        end else if (inc_rise) begin
          addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
        if (ena_s) begin
          state_d = ARM;
          cnt_d   = CNT_W'(RST_CYC - 1);
        end
      end
      ARM: begin
        if (!ena_s) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (!ena_s) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Project reset is released only while the next state is RUN, so DRAIN never sees it high.
    prst_d = (state_d == RUN) & pad_rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsel_q  <= 2'b11;
      inc_q   <= 3'b000;
      ena_q   <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      prst_q  <= 1'b0;
    end else begin
      rsel_q  <= rsel_d;
      inc_q   <= inc_d;
      ena_q   <= ena_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      prst_q  <= prst_d;
    end
  end

  // Unselected projects and an idle controller see all-zero input words.
  always_comb begin
    proj_ena = '0;
    proj_iw  = '0;
    sel_ow   = '0;
    if (state_q != IDLE) begin
      proj_ena[addr_q]                 = 1'b1;
      proj_iw[int'(addr_q) * 18 +: 18] = {pad_uio_in, pad_ui_in, prst_q, pad_clk};
    end
    if (state_q == RUN) begin
      sel_ow = proj_ow[int'(addr_q) * 24 +: 24];
    end
  end

  assign pad_uio_oe  = sel_ow[23:16];
  assign pad_uio_out = sel_ow[15:8];
  assign pad_uo_out  = sel_ow[7:0];
  assign cur_addr    = addr_q;
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Randomised and directed bench for tt_proj_mux_ctrl against a cycle-level
// behavioural model of the selector, sequencer and muxes.
module tb_tt_proj_mux_ctrl;
  localparam int N = 32;
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_rst_n = 1'b1, sel_inc = 1'b0, sel_ena = 1'b0;
  logic pad_clk = 1'b0, pad_rst_n = 1'b1;
  logic [7:0] pad_ui_in = '0, pad_uio_in = '0;
  logic [N*24-1:0] proj_ow = '0;
  logic [N*18-1:0] proj_iw;
  logic [N-1:0] proj_ena;
  logic [7:0] pad_uo_out, pad_uio_out, pad_uio_oe;
  logic [4:0] cur_addr;
  logic running;

  tt_proj_mux_ctrl #(.N_PROJ(N), .ADDR_W(5), .RST_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc),
    .sel_ena(sel_ena), .pad_clk(pad_clk), .pad_rst_n(pad_rst_n),
    .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in), .proj_ow(proj_ow),
    .proj_iw(proj_iw), .proj_ena(proj_ena), .pad_uo_out(pad_uo_out),
    .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe), .cur_addr(cur_addr),
    .running(running)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit rand_pads = 1'b1;

  // Model: mode, selected project, cycles left in ARM/DRAIN, registered project reset.
  int m_mode, m_addr, m_left;
  bit m_prst;
  bit ena_h[2], rst_h[2], inc_h[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [N*18-1:0] act, input logic [N*18-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_addr = 0; m_left = 0; m_prst = 1'b0;
    ena_h[0] = 0; ena_h[1] = 0;
    rst_h[0] = 1; rst_h[1] = 1;
    inc_h[0] = 0; inc_h[1] = 0; inc_h[2] = 0;
  endtask

  task automatic model_step();
    bit ena, clr, rise;
    ena  = ena_h[1];
    clr  = !rst_h[1];
    rise = inc_h[1] && !inc_h[2];
    case (m_mode)
      M_IDLE: begin
        if (clr) m_addr = 0;
        else if (rise) m_addr = (m_addr + 1) % N;
        if (ena) begin m_mode = M_ARM; m_left = 4; end
      end
      M_ARM: begin
        if (!ena) begin m_mode = M_DRAIN; m_left = 2; end
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
      end
      M_RUN: if (!ena) begin m_mode = M_DRAIN; m_left = 2; end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
    m_prst = (m_mode == M_RUN) && pad_rst_n;
    inc_h[2] = inc_h[1]; inc_h[1] = inc_h[0]; inc_h[0] = sel_inc;
    ena_h[1] = ena_h[0]; ena_h[0] = sel_ena;
    rst_h[1] = rst_h[0]; rst_h[0] = sel_rst_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check_model();
    logic [31:0] e_ena;
    logic [N*18-1:0] e_iw;
    logic [23:0] e_ow;
    e_ena = '0; e_iw = '0; e_ow = '0;
    if (m_mode != M_IDLE) begin
      e_ena[m_addr] = 1'b1;
      e_iw[m_addr*18 +: 18] = {pad_uio_in, pad_ui_in, m_prst, pad_clk};
    end
    if (m_mode == M_RUN) e_ow = proj_ow[m_addr*24 +: 24];
    chk("cur_addr", 32'(cur_addr), 32'(m_addr));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("proj_ena", proj_ena, e_ena);
    chk("pads", {8'h0, pad_uio_oe, pad_uio_out, pad_uo_out}, {8'h0, e_ow});
    chk_wide("proj_iw", proj_iw, e_iw);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    check_model();
  end

  initial forever begin
    @(negedge clk);
    pad_clk = 1'($urandom_range(0, 1));
    if (rand_pads) begin
      pad_ui_in  = 8'($urandom);
      pad_uio_in = 8'($urandom);
      pad_rst_n  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) proj_ow[i*24 +: 24] = 24'($urandom);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_inc();
    @(negedge clk); sel_inc = 1'b1; cyc(4); sel_inc = 1'b0; cyc(4);
  endtask

  task automatic pulse_clr();
    @(negedge clk); sel_rst_n = 1'b0; cyc(4); sel_rst_n = 1'b1; cyc(4);
  endtask

  task automatic wait_ena(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      sample();
      if (proj_ena != '0) ok = 1;
    end
    chk({nm, "_ena_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      sample();
      if (proj_ena == '0) ok = 1;
    end
    chk({nm, "_idle_seen"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int cnt;
    bit ran, ok;
    logic [N*18-1:0] masked;
    cyc(4);
    rst_n = 1'b1;
    sample();
    chk("reset_addr", 32'(cur_addr), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_ena", proj_ena, 32'd0);

    repeat (3) pulse_inc();
    chk("addr_after_3_inc", 32'(cur_addr), 32'd3);
    @(negedge clk); sel_ena = 1'b1;
    wait_ena("arm");
    chk("arm_ena_onehot", proj_ena, 32'h8);
    cnt = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      sample();
      if (running) ok = 1; else cnt++;
    end
    chk("arm_cycles", 32'(cnt), 32'd4);

    rand_pads = 1'b0;
    @(negedge clk);
    proj_ow = '1;
    proj_ow[3*24 +: 24] = 24'hA55A3C;
    pad_rst_n = 1'b0;
    sample();
    chk("uio_oe", 32'(pad_uio_oe), 32'hA5);
    chk("uio_out", 32'(pad_uio_out), 32'h5A);
    chk("uo_out", 32'(pad_uo_out), 32'h3C);
    masked = proj_iw;
    masked[3*18 +: 18] = '0;
    chk_wide("unselected_iw_zero", masked, '0);
    chk("prst_low", 32'(proj_iw[3*18+1]), 32'd0);
    @(negedge clk); pad_rst_n = 1'b1;
    sample();
    chk("prst_high", 32'(proj_iw[3*18+1]), 32'd1);

    pulse_inc();
    pulse_clr();
    chk("addr_frozen_run", 32'(cur_addr), 32'd3);
    @(negedge clk); sel_ena = 1'b0;
    cnt = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      sample();
      if (proj_ena == '0) ok = 1;
      else if (!running) begin
        cnt++;
        chk("drain_prst", 32'(proj_iw[3*18+1]), 32'd0);
      end
    end
    chk("drain_cycles", 32'(cnt), 32'd2);
    chk("idle_pads", {8'h0, pad_uio_oe, pad_uio_out, pad_uo_out}, 32'd0);
    rand_pads = 1'b1;

    repeat (28) pulse_inc();
    chk("addr_31", 32'(cur_addr), 32'd31);
    pulse_inc();
    chk("addr_wrap", 32'(cur_addr), 32'd0);
    repeat (2) pulse_inc();
    chk("addr_2", 32'(cur_addr), 32'd2);
    @(negedge clk); sel_rst_n = 1'b0; sel_inc = 1'b1;
    cyc(4); sel_rst_n = 1'b1; sel_inc = 1'b0; cyc(4);
    chk("clr_beats_inc", 32'(cur_addr), 32'd0);

    @(negedge clk); sel_ena = 1'b1;
    wait_ena("abort");
    @(negedge clk); sel_ena = 1'b0;
    ran = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      sample();
      if (running) ran = 1;
      if (proj_ena == '0) ok = 1;
    end
    chk("abort_never_run", 32'(ran), 32'd0);
    chk("abort_idle", proj_ena, 32'd0);

    @(negedge clk); sel_inc = 1'b1; sel_ena = 1'b1;
    wait_ena("inc_ena");
    chk("inc_ena_addr", 32'(cur_addr), 32'd1);
    chk("inc_ena_onehot", proj_ena, 32'h2);
    @(negedge clk); sel_inc = 1'b0; cyc(8);
    sel_ena = 1'b0;
    wait_idle("inc_ena");

    pulse_clr();
    repeat (7) pulse_inc();
    @(negedge clk); sel_ena = 1'b1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      sample();
      if (running) ok = 1;
    end
    chk("run7_reached", 32'(ok), 32'd1);
    chk("run7_addr", 32'(cur_addr), 32'd7);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("async_ena", proj_ena, 32'd0);
    chk_wide("async_iw", proj_iw, '0);
    chk("async_pads", {8'h0, pad_uio_oe, pad_uio_out, pad_uo_out}, 32'd0);
    chk("async_running", 32'(running), 32'd0);
    chk("async_addr", 32'(cur_addr), 32'd0);
    sel_ena = 1'b0;
    cyc(3); rst_n = 1'b1;
    sample();
    chk("post_rst_addr", 32'(cur_addr), 32'd0);
    chk("post_rst_running", 32'(running), 32'd0);

    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      sel_inc   = 1'($urandom_range(0, 1));
      sel_ena   = ($urandom_range(0, 2) != 0);
      sel_rst_n = ($urandom_range(0, 5) != 0);
      cyc($urandom_range(1, 8));
    end
    @(negedge clk); sel_ena = 1'b0; sel_rst_n = 1'b1; sel_inc = 1'b0;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
